mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning data RAM address width (depth 2^RAM_AW words).
REQ-002 SHALL have parameter PRESCALE, default 50000, meaning CLK cycles per timer tick.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 CLR  input  1  reset; synchronous and active-high.
REQ-005 w1  input  1  write strobe from the CPU; a write commits on the CLK edge where w1=1.
REQ-006 addr1  input  16  CPU word address.
REQ-007 data1  input  16  CPU write data.
REQ-008 external_din  output  18  read data returned to the CPU: {2'b00, word}.
REQ-009 switches  input  16  asynchronous board switches.
REQ-010 leds  output  16  LED register contents.
REQ-011 timer_irq  output  1  sticky timer-match flag.

Function
REQ-012 addr1[15]=0 SHALL select data RAM at index addr1[RAM_AW-1:0]; higher bits SHALL be ignored (aliasing).
REQ-013 addr1[15]=1 SHALL select I/O: 0x8000 LED (R/W), 0x8001 SWITCH (RO), 0x8002 COUNT (R; write clears), 0x8003 COMPARE (R/W), 0x8004 STATUS (bit0 = match flag; W1C).
REQ-014 Reads SHALL have one-cycle latency: external_din at edge N+1 reflects addr1 sampled at edge N, read-before-write (old data when w1=1 on the same address).
REQ-015 Unmapped I/O reads SHALL return 0; writes to unmapped I/O or to SWITCH SHALL be ignored.
REQ-016 switches SHALL pass through a 2-flop synchronizer; SWITCH reads return the second flop.
REQ-017 Prescaler SHALL count 0..PRESCALE-1 and assert a one-cycle tick on reaching PRESCALE-1, then wrap to 0.
REQ-018 COUNT SHALL increment by 1 on each tick, wrapping 0xFFFF -> 0x0000.
REQ-019 A tick where COUNT equals COMPARE (pre-increment value) SHALL set the match flag.
REQ-020 Write to COUNT coincident with a tick: the write SHALL win (COUNT=0) and the prescaler SHALL also be cleared to 0.
REQ-021 Flag set and W1C clear in the same cycle: set SHALL win.
REQ-022 STATUS write with data1[0]=0 SHALL leave the flag unchanged.
REQ-023 timer_irq SHALL equal the match flag; leds SHALL equal the LED register.

Reset
REQ-024 While CLR=1 at an edge: external_din=0, leds=0, COUNT=0, prescaler=0, COMPARE=0xFFFF, flag=0, synchronizer flops=0.
REQ-025 CLR SHALL take priority over any coincident write or tick.
REQ-026 RAM contents SHALL NOT be reset; RAM writes while CLR=1 SHALL be ignored.
REQ-027 After CLR deasserts, first tick SHALL occur PRESCALE cycles later.

Structure
REQ-028 I/O address constants (0x8000-0x8004) and STATUS bit positions SHALL live in a shared package used by the CPU-side software build and the bench.
REQ-029 The timer (prescaler, COUNT, COMPARE, flag) SHALL be one sub-module, mem_timer; RAM and decode remain in mem_responder.
REQ-030 RAM SHALL be inferable as synchronous block RAM (single port, registered read).

Verification (PRESCALE=4 on bench)
REQ-031 Write 0x1234 to 0x0005, then read 0x0005 -> external_din=0x01234? no: 18'h01234 one cycle after address; read 0x0405 (alias, RAM_AW=10) -> 18'h01234.
REQ-032 Write 0xA5A5 to 0x8000 -> leds=0xA5A5 next edge; read 0x8000 -> 18'h0A5A5; write to 0x8001 -> no state change.
REQ-033 switches=0x00F0 applied -> SWITCH read returns 0x00F0 no earlier than 2 edges after change.
REQ-034 COMPARE=3, run 16 cycles -> COUNT=4, timer_irq=1 after the tick at COUNT=3; write 0x0001 to 0x8004 -> timer_irq=0; same-cycle set+clear -> timer_irq stays 1.
REQ-035 Preload COUNT to 0xFFFF via wrap (COMPARE=0xFFFF) -> next tick COUNT=0x0000, timer_irq=1.
REQ-036 Assert CLR mid-run with w1=1 to 0x8000 -> leds=0, COUNT=0, COMPARE=0xFFFF, external_din=0; previously written RAM word still readable after release.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared memory-map constants for the CPU-side responder: I/O addresses,
// STATUS bit positions and the I/O address decoder.
package mem_responder_pkg;

  localparam logic [15:0] IO_LED     = 16'h8000;
  localparam logic [15:0] IO_SWITCH  = 16'h8001;
  localparam logic [15:0] IO_COUNT   = 16'h8002;
  localparam logic [15:0] IO_COMPARE = 16'h8003;
  localparam logic [15:0] IO_STATUS  = 16'h8004;

  localparam int STATUS_MATCH_BIT = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SWITCH,
    SEL_COUNT,
    SEL_COMPARE,
    SEL_STATUS
  } io_sel_e;

  // Full 16-bit compare: anything else in the I/O half is unmapped.
  function automatic io_sel_e io_decode(input logic [15:0] addr);
    io_sel_e sel;
    case (addr)
      IO_LED:     sel = SEL_LED;
      IO_SWITCH:  sel = SEL_SWITCH;
      IO_COUNT:   sel = SEL_COUNT;
      IO_COMPARE: sel = SEL_COMPARE;
      IO_STATUS:  sel = SEL_STATUS;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus between the processor and mem_responder: write strobe, address,
// write data and the one-cycle-latency read data.
interface mem_responder_if;

  logic        w1;
  logic [15:0] addr1;
  logic [15:0] data1;
  logic [17:0] external_din;

  modport master (output w1, output addr1, output data1, input external_din);
  modport slave  (input w1, input addr1, input data1, output external_din);

endinterface

// File: rtl/mem_timer.sv
// Prescaled 16-bit event counter with a compare register and a sticky
// match flag; the flag clears only through an explicit write-one-to-clear.
module mem_timer #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        count_clr,
  input  logic        compare_we,
  input  logic [15:0] compare_wdata,
  input  logic        match_clr,
  output logic [15:0] count,
  output logic [15:0] compare,
  output logic        flag
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      pre     <= '0;
      count   <= '0;
      compare <= 16'hFFFF;
      flag    <= 1'b0;
    end else begin
      // A COUNT write restarts the whole tick period, not just the count.
      if (count_clr || tick) pre <= '0;
      else                   pre <= pre + 1'b1;

      if (count_clr) count <= '0;
      else if (tick) count <= count + 16'd1;

      if (compare_we) compare <= compare_wdata;

      if (tick && (count == compare)) flag <= 1'b1;
      else if (match_clr)             flag <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: word RAM in the low half of the address
// space, LED/switch/timer registers in the high half, registered read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int PRESCALE = 50000
) (
  input  logic            CLK,
  input  logic            CLR,
  mem_responder_if.slave  bus,
  input  logic [15:0]     switches,
  output logic [15:0]     leds,
  output logic            timer_irq
);

  logic              is_io;
  io_sel_e           sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;

  logic [15:0] ram [2**RAM_AW];
  logic [15:0] ram_q;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] led_q;
  logic [15:0] io_rdata;
  logic [15:0] io_q;
  logic        ram_sel_q;

  logic [15:0] count;
  logic [15:0] compare;
  logic        flag;
  logic        count_clr;
  logic        compare_we;
  logic        match_clr;

  assign is_io   = bus.addr1[15];
  assign sel     = is_io ? io_decode(bus.addr1) : SEL_NONE;
  assign ram_idx = bus.addr1[RAM_AW-1:0];
  assign ram_we  = bus.w1 && !is_io && !CLR;

  // No reset on the array or its output register so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_idx] <= bus.data1;
    ram_q <= ram[ram_idx];
  end

  assign count_clr  = bus.w1 && (sel == SEL_COUNT);
  assign compare_we = bus.w1 && (sel == SEL_COMPARE);
  assign match_clr  = bus.w1 && (sel == SEL_STATUS) && bus.data1[STATUS_MATCH_BIT];

  mem_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk           (CLK),
    .clr           (CLR),
    .count_clr     (count_clr),
    .compare_we    (compare_we),
    .compare_wdata (bus.data1),
    .match_clr     (match_clr),
    .count         (count),
    .compare       (compare),
    .flag          (flag)
  );

  always_comb begin
    io_rdata = '0;
    case (sel)
      SEL_LED:     io_rdata = led_q;
      SEL_SWITCH:  io_rdata = sw_sync;
      SEL_COUNT:   io_rdata = count;
      SEL_COMPARE: io_rdata = compare;
      SEL_STATUS:  io_rdata[STATUS_MATCH_BIT] = flag;
      default:     io_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      led_q     <= '0;
      io_q      <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      sw_meta   <= switches;
      sw_sync   <= sw_meta;
      if (bus.w1 && (sel == SEL_LED)) led_q <= bus.data1;
      io_q      <= io_rdata;
      ram_sel_q <= !is_io;
    end
  end

  // ram_sel_q is cleared by CLR, which forces the read bus to zero in reset.
  assign bus.external_din = ram_sel_q ? {2'b00, ram_q} : {2'b00, io_q};
  assign leds             = led_q;
  assign timer_irq        = flag;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed bus ops push expected read data into a
// scoreboard that a negedge monitor drains; a second instance covers COUNT wrap.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        clr2 = 1'b1;
  logic [15:0] switches = 16'h0000;
  logic [15:0] sw2 = 16'h0000;
  logic [15:0] leds, leds2;
  logic        timer_irq, irq2;

  mem_responder_if bus ();
  mem_responder_if bus2 ();

  always #5 CLK = ~CLK;

  mem_responder #(.RAM_AW(10), .PRESCALE(4)) u_dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .bus       (bus),
    .switches  (switches),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  mem_responder #(.RAM_AW(4), .PRESCALE(1)) u_wrap (
    .CLK       (CLK),
    .CLR       (clr2),
    .bus       (bus2),
    .switches  (sw2),
    .leds      (leds2),
    .timer_irq (irq2)
  );

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q [$];
  string       nm_q  [$];
  logic        rd_flag = 1'b0;
  logic        rd_pend = 1'b0;

  always @(posedge CLK) rd_pend <= rd_flag;

  always @(negedge CLK) begin
    if (rd_pend) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h exp=<none>", bus.external_din);
      end else begin
        logic [17:0] e;
        string       n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (bus.external_din !== e) begin
          bad++;
          $display("FAIL %s got=%h exp=%h", n, bus.external_din, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic op(input logic w, input logic [15:0] a, input logic [15:0] d,
                    input logic chk, input logic [17:0] e, input string nm);
    bus.w1    = w;
    bus.addr1 = a;
    bus.data1 = d;
    rd_flag   = chk;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(posedge CLK);
    #1;
    bus.w1  = 1'b0;
    rd_flag = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    op(1'b1, a, d, 1'b0, 18'h0, "");
  endtask

  task automatic rd(input logic [15:0] a, input logic [17:0] e, input string nm);
    op(1'b0, a, 16'h0000, 1'b1, e, nm);
  endtask

  task automatic idle(input int n);
    bus.w1 = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    bus.w1     = 1'b0;
    bus.addr1  = 16'h0000;
    bus.data1  = 16'h0000;
    bus2.w1    = 1'b0;
    bus2.addr1 = IO_COUNT;
    bus2.data1 = 16'h0000;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_leds", {2'b00, leds}, 18'h0);
    check("rst_irq", {17'b0, timer_irq}, 18'h0);
    check("rst_din", bus.external_din, 18'h0);
    CLR = 1'b0;

    rd(IO_COUNT,   18'h00000, "rst_count");
    rd(IO_COMPARE, 18'h0FFFF, "rst_compare");
    rd(IO_STATUS,  18'h00000, "rst_status");

    // RAM, aliasing, read-before-write
    wr(16'h0005, 16'h1234);
    rd(16'h0005, 18'h01234, "ram_rd");
    rd(16'h0405, 18'h01234, "ram_alias");
    wr(16'h0006, 16'h1111);
    op(1'b1, 16'h0006, 16'h2222, 1'b1, 18'h01111, "ram_rbw");
    rd(16'h0006, 18'h02222, "ram_rbw_new");

    // LED, read-only SWITCH, unmapped I/O
    wr(IO_LED, 16'hA5A5);
    check("led_wr", {2'b00, leds}, 18'h0A5A5);
    rd(IO_LED, 18'h0A5A5, "led_rd");
    wr(IO_SWITCH, 16'hFFFF);
    check("sw_wr_ignored", {2'b00, leds}, 18'h0A5A5);
    rd(IO_SWITCH, 18'h00000, "sw_ro");
    rd(16'h8005, 18'h00000, "unmapped_8005");
    wr(16'h8007, 16'h1234);
    rd(16'h9000, 18'h00000, "unmapped_9000");

    // switch synchronizer: two edges of delay
    switches = 16'h00F0;
    rd(IO_SWITCH, 18'h00000, "sw_edge1");
    rd(IO_SWITCH, 18'h00000, "sw_edge2");
    rd(IO_SWITCH, 18'h000F0, "sw_edge3");

    // timer: COUNT cleared at edge W, ticks at W+4k
    wr(IO_COUNT, 16'h0000);
    wr(IO_COMPARE, 16'h0003);
    idle(14);
    check("irq_before_match", {17'b0, timer_irq}, 18'h0);
    idle(1);
    check("irq_at_match", {17'b0, timer_irq}, 18'h1);
    rd(IO_COUNT, 18'h00004, "count_after_16");
    rd(IO_STATUS, 18'h00001, "status_set");
    wr(IO_STATUS, 16'h0001);
    check("irq_w1c", {17'b0, timer_irq}, 18'h0);
    rd(IO_STATUS, 18'h00000, "status_cleared");

    // set and clear land on the same edge
    wr(IO_COMPARE, 16'h0000);
    wr(IO_COUNT, 16'h0000);
    idle(3);
    wr(IO_STATUS, 16'h0001);
    check("irq_set_wins", {17'b0, timer_irq}, 18'h1);
    wr(IO_STATUS, 16'h0000);
    check("irq_w0_keeps", {17'b0, timer_irq}, 18'h1);
    wr(IO_STATUS, 16'h0001);
    check("irq_w1c_2", {17'b0, timer_irq}, 18'h0);

    // COUNT write on a tick edge wins
    wr(IO_COMPARE, 16'h00FF);
    wr(IO_COUNT, 16'h0000);
    idle(3);
    rd(IO_COUNT, 18'h00000, "count_wr_wins");
    rd(IO_COUNT, 18'h00001, "count_next_tick");

    // CLR mid-run with a coincident LED write, then a RAM write
    rd(IO_LED, 18'h0A5A5, "led_before_clr");
    CLR       = 1'b1;
    bus.w1    = 1'b1;
    bus.addr1 = IO_LED;
    bus.data1 = 16'h5A5A;
    @(posedge CLK);
    #1;
    check("clr_leds", {2'b00, leds}, 18'h0);
    check("clr_din", bus.external_din, 18'h0);
    bus.addr1 = 16'h0005;
    bus.data1 = 16'hDEAD;
    @(posedge CLK);
    #1;
    CLR    = 1'b0;
    bus.w1 = 1'b0;
    rd(IO_LED,     18'h00000, "led_after_clr");
    rd(IO_COUNT,   18'h00000, "count_after_clr");
    rd(IO_COMPARE, 18'h0FFFF, "compare_after_clr");
    rd(16'h0005,   18'h01234, "ram_kept");

    // COUNT wrap on the PRESCALE=1 instance: count == k after k edges
    clr2 = 1'b0;
    repeat (65535) @(posedge CLK);
    #1;
    check("wrap_irq_pre", {17'b0, irq2}, 18'h0);
    check("wrap_count_fffe", bus2.external_din, 18'h0FFFE);
    @(posedge CLK);
    #1;
    check("wrap_irq", {17'b0, irq2}, 18'h1);
    check("wrap_count_ffff", bus2.external_din, 18'h0FFFF);
    @(posedge CLK);
    #1;
    check("wrap_count_0", bus2.external_din, 18'h00000);
    check("wrap_irq_sticky", {17'b0, irq2}, 18'h1);

    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
